// File: rtl/byte_pair_deser.sv
// byte_pair_deser: serial byte stream -> registered low/high byte pairs.
// One byte is staged in 'lo' until its partner arrives; a flush request
// emits a staged odd byte padded with PAD so packets can be drained.
module byte_pair_deser #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PAD   = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  logic [WIDTH-1:0] lo;
  logic             lo_valid;
  logic             slot_free;
  logic             accept;
  logic             pair_load;
  logic             flush_load;
  logic             any_load;

  // Output slot frees up when empty or being drained this cycle.
  assign slot_free  = !out_valid || out_ready;
  // A staged byte only blocks input when its pair could not be written.
  assign in_ready   = !rst && (!lo_valid || slot_free);
  assign accept     = in_valid && in_ready;
  // accept with lo_valid implies slot_free, so the pair slot is available.
  assign pair_load  = accept && lo_valid;
  // Accept wins over flush: a flush only fires when no byte is taken.
  assign flush_load = flush && lo_valid && slot_free && !accept;
  assign any_load   = pair_load || flush_load;

  // Staging register for the first byte of a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo       <= '0;
      lo_valid <= 1'b0;
    end else if (any_load) begin
      lo_valid <= 1'b0;
    end else if (accept) begin
      lo       <= in_data;
      lo_valid <= 1'b1;
    end
  end

  // Output pair register: load, drain, or hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_lo    <= '0;
      out_hi    <= '0;
      odd       <= 1'b0;
      out_valid <= 1'b0;
    end else if (any_load) begin
      out_lo    <= lo;
      out_hi    <= pair_load ? in_data : PAD;
      odd       <= flush_load;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count of pairs loaded; wraps silently.
  always_ff @(posedge clk) begin
    if (rst)           pair_cnt <= '0;
    else if (any_load) pair_cnt <= pair_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_byte_pair_deser.sv
// Bench for byte_pair_deser: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of held bytes and pairs.
module tb_byte_pair_deser;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic          in_ready, odd, out_valid;
  logic [W-1:0]  in_data, out_lo, out_hi;
  logic [CW-1:0] pair_cnt;

  always #5 clk = ~clk;

  byte_pair_deser #(.WIDTH(W), .PAD(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_lo(out_lo), .out_hi(out_hi),
    .odd(odd), .out_valid(out_valid), .out_ready(out_ready),
    .pair_cnt(pair_cnt)
  );

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       odd;
  } pair_t;

  logic [7:0]  held_q[$];   // bytes waiting for a partner (0 or 1)
  pair_t       slot_q[$];   // pair presented downstream (0 or 1)
  int unsigned m_cnt;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, slot_q.size() != 0});
    if (slot_q.size() != 0) begin
      chk("out_lo", {24'd0, out_lo}, {24'd0, slot_q[0].lo});
      chk("out_hi", {24'd0, out_hi}, {24'd0, slot_q[0].hi});
      chk("odd",    {31'd0, odd},    {31'd0, slot_q[0].odd});
    end
    chk("pair_cnt", {24'd0, pair_cnt}, m_cnt);
  endtask

  task automatic chk_zero();
    chk("rst_lo",  {24'd0, out_lo}, 32'd0);
    chk("rst_hi",  {24'd0, out_hi}, 32'd0);
    chk("rst_odd", {31'd0, odd},    32'd0);
  endtask

  // One clock: drive inputs, check state from the previous edge plus the
  // combinational ready, then advance the model across the coming edge.
  task automatic step(input logic r_st, input logic v, input logic [7:0] d,
                      input logic f, input logic r);
    pair_t p;
    bit    rdy, acc, sf, pl;
    rst = r_st; in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
    sf  = (slot_q.size() == 0) || r;
    rdy = !r_st && ((held_q.size() == 0) || sf);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check_outputs();
    if (r_st) begin
      held_q.delete();
      slot_q.delete();
      m_cnt = 0;
    end else begin
      acc = v && rdy;
      pl  = 1'b0;
      p   = '0;
      if (acc && held_q.size() != 0) begin
        p.lo = held_q.pop_front(); p.hi = d; p.odd = 1'b0; pl = 1'b1;
      end else if (acc) begin
        held_q.push_back(d);
      end else if (f && held_q.size() != 0 && sf) begin
        p.lo = held_q.pop_front(); p.hi = 8'h00; p.odd = 1'b1; pl = 1'b1;
      end
      if (slot_q.size() != 0 && r) void'(slot_q.pop_front());
      if (pl) begin
        slot_q.push_back(p);
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 8'h00, 1'b0, r);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_zero();

    // Streaming with out_ready high
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
    idle(1'b1);
    chk("cnt_after_stream", {24'd0, pair_cnt}, 32'd2);

    // Flush of an odd byte, then flush with nothing held
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1'b1);

    // Backpressure: pair held, third byte staged, fourth refused
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h04, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Accept beats flush in the same cycle
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset while HALF_FULL discards everything
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    chk_zero();
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    // Counter wrap: stream until the count sits at its maximum, then one more pair
    for (int i = 0; i < 2000 && m_cnt != (1 << CW) - 1; i++)
      step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1);
    if (held_q.size() != 0) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1'b1);
    chk("cnt_at_max", {24'd0, pair_cnt}, 32'hFF);
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    idle(1'b1);
    chk("cnt_wrap", {24'd0, pair_cnt}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
